id_stream_arb: RTL and testbench



---
 rtl/id_pkg.sv | 28 ++
 rtl/id_step.sv | 23 ++
 rtl/id_stream_arb.sv | 140 ++++++++++++++
 tb/tb_id_stream_arb.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared definitions for the identifier-recognition arbiter: recognizer state
// encoding and the ASCII ranges that make up the letter and digit classes.
package id_pkg;

    // Encoding 3 is never produced; the step function treats it like REJ.
    typedef enum logic [1:0] {
        ST_REJ = 2'd0,
        ST_LET = 2'd1,
        ST_ACC = 2'd2
    } id_state_e;

    localparam logic [7:0] CH_UPPER_LO = 8'd65;   // 'A'
    localparam logic [7:0] CH_UPPER_HI = 8'd90;   // 'Z'
    localparam logic [7:0] CH_LOWER_LO = 8'd97;   // 'a'
    localparam logic [7:0] CH_LOWER_HI = 8'd122;  // 'z'
    localparam logic [7:0] CH_DIGIT_LO = 8'd48;   // '0'
    localparam logic [7:0] CH_DIGIT_HI = 8'd57;   // '9'

    function automatic logic is_letter(input logic [7:0] ch);
        return ((ch >= CH_UPPER_LO) && (ch <= CH_UPPER_HI)) ||
               ((ch >= CH_LOWER_LO) && (ch <= CH_LOWER_HI));
    endfunction

    function automatic logic is_digit(input logic [7:0] ch);
        return (ch >= CH_DIGIT_LO) && (ch <= CH_DIGIT_HI);
    endfunction

endpackage

// File: rtl/id_step.sv
// Combinational identifier-recognizer step: letter starts/continues an
// identifier, a digit after a letter accepts it, anything else rejects.
module id_step
    import id_pkg::*;
(
    input  id_state_e  state,
    input  logic [7:0] ch,
    output id_state_e  next_state,
    output logic       hit
);

    // Next recognizer state and the non-ACC -> ACC transition flag
    always_comb begin
        next_state = ST_REJ;
        if (is_letter(ch)) begin
            next_state = ST_LET;
        end else if (is_digit(ch) && ((state == ST_LET) || (state == ST_ACC))) begin
            next_state = ST_ACC;
        end
        hit = (next_state == ST_ACC) && (state != ST_ACC);
    end

endmodule

// File: rtl/id_stream_arb.sv
// Round-robin sharing of one id_step between character streams A and B, with
// per-stream recognizer context, per-stream saturating hit counters and a
// single valid/ready result port.
module id_stream_arb
    import id_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [7:0]       a_char,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [7:0]       b_char,
    output logic             b_ready,
    input  logic             clr_a,
    input  logic             clr_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_src,
    output logic             res_match,
    output logic [CNT_W-1:0] hit_cnt_a,
    output logic [CNT_W-1:0] hit_cnt_b
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    id_state_e        ctx_a_q, ctx_a_d;
    id_state_e        ctx_b_q, ctx_b_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
    logic             last_grant_q, last_grant_d;
    logic             res_valid_q, res_valid_d;
    logic             res_src_q, res_src_d;
    logic             res_match_q, res_match_d;

    logic             can_issue;
    logic             grant_a;
    logic             grant_b;
    id_state_e        step_cur;
    logic [7:0]       step_char;
    id_state_e        step_next;
    logic             step_hit;

    // Grant: nothing while a result is stalled, otherwise round-robin on ties
    always_comb begin
        can_issue = !res_valid_q || res_ready;
        grant_a   = can_issue && a_valid && (!b_valid || (last_grant_q == SRC_B));
        grant_b   = can_issue && b_valid && (!a_valid || (last_grant_q == SRC_A));
    end

    // Feed the shared step with the granted stream; a same-cycle clear means
    // the character steps from LET rather than the stored context
    always_comb begin
        if (grant_b) begin
            step_cur  = clr_b ? ST_LET : ctx_b_q;
            step_char = b_char;
        end else begin
            step_cur  = clr_a ? ST_LET : ctx_a_q;
            step_char = a_char;
        end
    end

    id_step u_step (
        .state      (step_cur),
        .ch         (step_char),
        .next_state (step_next),
        .hit        (step_hit)
    );

    // Next contexts, counters, arbitration history and result registers
    always_comb begin
        ctx_a_d = clr_a ? ST_LET : ctx_a_q;
        ctx_b_d = clr_b ? ST_LET : ctx_b_q;
        cnt_a_d = clr_a ? '0 : cnt_a_q;
        cnt_b_d = clr_b ? '0 : cnt_b_q;
        last_grant_d = last_grant_q;
        res_valid_d  = res_valid_q;
        res_src_d    = res_src_q;
        res_match_d  = res_match_q;

        if (grant_a) begin
            ctx_a_d = step_next;
            if (step_hit && (cnt_a_d != CNT_MAX)) begin
                cnt_a_d = cnt_a_d + CNT_ONE;
            end
        end
        if (grant_b) begin
            ctx_b_d = step_next;
            if (step_hit && (cnt_b_d != CNT_MAX)) begin
                cnt_b_d = cnt_b_d + CNT_ONE;
            end
        end

        if (grant_a || grant_b) begin
            last_grant_d = grant_b ? SRC_B : SRC_A;
            res_valid_d  = 1'b1;
            res_src_d    = grant_b ? SRC_B : SRC_A;
            res_match_d  = (step_next == ST_ACC);
        end else if (res_ready) begin
            res_valid_d  = 1'b0;
        end
    end

    // State registers; last grant starts at B so A wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctx_a_q      <= ST_LET;
            ctx_b_q      <= ST_LET;
            cnt_a_q      <= '0;
            cnt_b_q      <= '0;
            last_grant_q <= SRC_B;
            res_valid_q  <= 1'b0;
            res_src_q    <= 1'b0;
            res_match_q  <= 1'b0;
        end else begin
            ctx_a_q      <= ctx_a_d;
            ctx_b_q      <= ctx_b_d;
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
            last_grant_q <= last_grant_d;
            res_valid_q  <= res_valid_d;
            res_src_q    <= res_src_d;
            res_match_q  <= res_match_d;
        end
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign res_valid = res_valid_q;
    assign res_src   = res_src_q;
    assign res_match = res_match_q;
    assign hit_cnt_a = cnt_a_q;
    assign hit_cnt_b = cnt_b_q;

endmodule

// File: tb/tb_id_stream_arb.sv
// Directed testbench for id_stream_arb (CNT_W = 2 so saturation is reachable).
module tb_id_stream_arb;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             a_valid = 1'b0;
    logic [7:0]       a_char = 8'd0;
    logic             a_ready;
    logic             b_valid = 1'b0;
    logic [7:0]       b_char = 8'd0;
    logic             b_ready;
    logic             clr_a = 1'b0;
    logic             clr_b = 1'b0;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic             res_src;
    logic             res_match;
    logic [CNT_W-1:0] hit_cnt_a;
    logic [CNT_W-1:0] hit_cnt_b;

    int checks = 0;
    int errors = 0;

    id_stream_arb #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_char    (a_char),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_char    (b_char),
        .b_ready   (b_ready),
        .clr_a     (clr_a),
        .clr_b     (clr_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_src   (res_src),
        .res_match (res_match),
        .hit_cnt_a (hit_cnt_a),
        .hit_cnt_b (hit_cnt_b)
    );

    always #5 clk = ~clk;

    // Reset with all inputs idle; returns 1 time unit after a rising edge
    task automatic do_reset();
        a_valid = 0; b_valid = 0; a_char = 0; b_char = 0;
        clr_a = 0; clr_b = 0; res_ready = 1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        a_valid = 0; b_valid = 0; clr_a = 0; clr_b = 0; res_ready = 1;
        rst_n = 0;
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
        checks++; if (res_src !== 1'b0) begin errors++; $display("FAIL reset_res_src got %b exp 0", res_src); end
        checks++; if (res_match !== 1'b0) begin errors++; $display("FAIL reset_res_match got %b exp 0", res_match); end
        checks++; if (hit_cnt_a !== 2'd0 || hit_cnt_b !== 2'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", hit_cnt_a, hit_cnt_b); end
        @(posedge clk); #1;
        rst_n = 1;
        a_valid = 1; a_char = "k"; b_valid = 1; b_char = "m";
        #1;
        checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL reset_first_tie got a_ready=%b b_ready=%b exp 1/0", a_ready, b_ready); end
        $display("test_reset: first tie a_ready=%b b_ready=%b", a_ready, b_ready);
        a_valid = 0; b_valid = 0;
    endtask

    task automatic test_single_a();
        string s = "a12";
        bit exp_m [3] = '{1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            a_valid = 1; a_char = s[i];
            #1;
            checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL single_a_ready[%0d] got %b exp 1", i, a_ready); end
            @(posedge clk); #1;
            checks++; if (res_valid !== 1'b1 || res_src !== 1'b0 || res_match !== exp_m[i]) begin
                errors++; $display("FAIL single_a_res[%0d] got v=%b s=%b m=%b exp v=1 s=0 m=%b", i, res_valid, res_src, res_match, exp_m[i]);
            end
            $display("single_a: char '%s' match=%b", a_char, res_match);
        end
        a_valid = 0;
        @(posedge clk); #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_a_drain got %b exp 0", res_valid); end
        checks++; if (hit_cnt_a !== 2'd1) begin errors++; $display("FAIL single_a_hits got %0d exp 1", hit_cnt_a); end
    endtask

    task automatic test_round_robin();
        string sa = "ab";
        string sb = "cd";
        int ia = 0;
        int ib = 0;
        bit exp_src [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            a_valid = 1; a_char = sa[ia % 2];
            b_valid = 1; b_char = sb[ib % 2];
            #1;
            checks++; if (a_ready !== !exp_src[c] || b_ready !== exp_src[c]) begin
                errors++; $display("FAIL rr_ready[%0d] got a=%b b=%b exp a=%b b=%b", c, a_ready, b_ready, !exp_src[c], exp_src[c]);
            end
            @(posedge clk); #1;
            checks++; if (res_valid !== 1'b1 || res_src !== exp_src[c] || res_match !== 1'b0) begin
                errors++; $display("FAIL rr_res[%0d] got v=%b s=%b m=%b exp v=1 s=%b m=0", c, res_valid, res_src, res_match, exp_src[c]);
            end
            $display("round_robin: cycle %0d src=%b", c, res_src);
            if (exp_src[c]) ib++; else ia++;
        end
        a_valid = 0; b_valid = 0;
    endtask

    task automatic test_backpressure();
        do_reset();
        a_valid = 1; a_char = "x";
        @(posedge clk); #1;
        checks++; if (res_valid !== 1'b1 || res_src !== 1'b0 || res_match !== 1'b0) begin
            errors++; $display("FAIL bp_first got v=%b s=%b m=%b exp 1/0/0", res_valid, res_src, res_match);
        end
        res_ready = 0; a_char = "1";
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0", c, a_ready); end
            @(posedge clk); #1;
            checks++; if (res_valid !== 1'b1 || res_src !== 1'b0 || res_match !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%b s=%b m=%b exp 1/0/0", c, res_valid, res_src, res_match);
            end
            $display("backpressure: hold cycle %0d v=%b m=%b", c, res_valid, res_match);
        end
        res_ready = 1;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", a_ready); end
        @(posedge clk); #1;
        checks++; if (res_valid !== 1'b1 || res_match !== 1'b1) begin
            errors++; $display("FAIL bp_next got v=%b m=%b exp 1/1", res_valid, res_match);
        end
        a_valid = 0;
    endtask

    task automatic test_interleave();
        string sa = "q1";
        string sb = "-9z";
        int ia = 0;
        int ib = 0;
        bit exp_src [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bit exp_m   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            a_valid = (ia < 2); a_char = (ia < 2) ? sa[ia] : 8'd0;
            b_valid = (ib < 3); b_char = (ib < 3) ? sb[ib] : 8'd0;
            #1;
            checks++; if (a_ready !== !exp_src[c] || b_ready !== exp_src[c]) begin
                errors++; $display("FAIL il_ready[%0d] got a=%b b=%b exp a=%b b=%b", c, a_ready, b_ready, !exp_src[c], exp_src[c]);
            end
            @(posedge clk); #1;
            checks++; if (res_valid !== 1'b1 || res_src !== exp_src[c] || res_match !== exp_m[c]) begin
                errors++; $display("FAIL il_res[%0d] got v=%b s=%b m=%b exp v=1 s=%b m=%b", c, res_valid, res_src, res_match, exp_src[c], exp_m[c]);
            end
            $display("interleave: cycle %0d src=%b match=%b", c, res_src, res_match);
            if (exp_src[c]) ib++; else ia++;
        end
        a_valid = 0; b_valid = 0;
        checks++; if (hit_cnt_a !== 2'd1 || hit_cnt_b !== 2'd0) begin
            errors++; $display("FAIL il_hits got a=%0d b=%0d exp 1/0", hit_cnt_a, hit_cnt_b);
        end
    endtask

    task automatic test_saturate();
        string s = "a1 a1 a1 a1 a1";
        do_reset();
        for (int i = 0; i < s.len(); i++) begin
            a_valid = 1; a_char = s[i];
            @(posedge clk); #1;
            if (i == 7) begin
                checks++; if (hit_cnt_a !== 2'd3) begin errors++; $display("FAIL sat_third got %0d exp 3", hit_cnt_a); end
            end
        end
        a_valid = 0;
        checks++; if (hit_cnt_a !== 2'd3) begin errors++; $display("FAIL sat_final got %0d exp 3", hit_cnt_a); end
        $display("saturate: hit_cnt_a=%0d after 5 hits", hit_cnt_a);
    endtask

    task automatic test_clear();
        string s = "b2";
        do_reset();
        for (int i = 0; i < 2; i++) begin
            b_valid = 1; b_char = s[i];
            @(posedge clk); #1;
        end
        b_valid = 0;
        s = "a1-";
        for (int i = 0; i < 3; i++) begin
            a_valid = 1; a_char = s[i];
            @(posedge clk); #1;
        end
        checks++; if (hit_cnt_a !== 2'd1 || hit_cnt_b !== 2'd1) begin
            errors++; $display("FAIL clr_setup got a=%0d b=%0d exp 1/1", hit_cnt_a, hit_cnt_b);
        end
        // A sits in REJ; clear together with '5' must step from LET
        a_valid = 1; a_char = "5"; clr_a = 1;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL clr_grant_ready got %b exp 1", a_ready); end
        @(posedge clk); #1;
        clr_a = 0; a_valid = 0;
        checks++; if (res_valid !== 1'b1 || res_match !== 1'b1) begin
            errors++; $display("FAIL clr_grant_res got v=%b m=%b exp 1/1", res_valid, res_match);
        end
        checks++; if (hit_cnt_a !== 2'd1 || hit_cnt_b !== 2'd1) begin
            errors++; $display("FAIL clr_grant_hits got a=%0d b=%0d exp 1/1", hit_cnt_a, hit_cnt_b);
        end
        $display("clear: clr_a with '5' match=%b hit_cnt_a=%0d", res_match, hit_cnt_a);
        // Clear alone while the result is stalled: res_* untouched
        res_ready = 0; clr_a = 1;
        @(posedge clk); #1;
        clr_a = 0;
        checks++; if (hit_cnt_a !== 2'd0 || hit_cnt_b !== 2'd1) begin
            errors++; $display("FAIL clr_only_hits got a=%0d b=%0d exp 0/1", hit_cnt_a, hit_cnt_b);
        end
        checks++; if (res_valid !== 1'b1 || res_src !== 1'b0 || res_match !== 1'b1) begin
            errors++; $display("FAIL clr_only_res got v=%b s=%b m=%b exp 1/0/1", res_valid, res_src, res_match);
        end
        res_ready = 1; a_valid = 1; a_char = "7";
        @(posedge clk); #1;
        a_valid = 0;
        checks++; if (res_match !== 1'b1 || hit_cnt_a !== 2'd1) begin
            errors++; $display("FAIL clr_after got m=%b hits=%0d exp 1/1", res_match, hit_cnt_a);
        end
    endtask

    task automatic test_async_reset();
        string s = "a1";
        do_reset();
        for (int i = 0; i < 2; i++) begin
            a_valid = 1; a_char = s[i];
            @(posedge clk); #1;
        end
        checks++; if (res_valid !== 1'b1 || res_match !== 1'b1 || hit_cnt_a !== 2'd1) begin
            errors++; $display("FAIL arst_pre got v=%b m=%b hits=%0d exp 1/1/1", res_valid, res_match, hit_cnt_a);
        end
        a_valid = 0;
        #2 rst_n = 0;
        #1;
        checks++; if (res_valid !== 1'b0 || res_src !== 1'b0 || res_match !== 1'b0 || hit_cnt_a !== 2'd0) begin
            errors++; $display("FAIL arst_now got v=%b s=%b m=%b hits=%0d exp 0/0/0/0", res_valid, res_src, res_match, hit_cnt_a);
        end
        $display("async_reset: outputs v=%b m=%b hits=%0d while rst_n=0", res_valid, res_match, hit_cnt_a);
        @(posedge clk); #1;
        rst_n = 1;
        // Context must be back at LET: '3' gives a fresh hit
        a_valid = 1; a_char = "3";
        @(posedge clk); #1;
        a_valid = 0;
        checks++; if (res_match !== 1'b1 || hit_cnt_a !== 2'd1) begin
            errors++; $display("FAIL arst_ctx got m=%b hits=%0d exp 1/1", res_match, hit_cnt_a);
        end
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_round_robin();
        test_backpressure();
        test_interleave();
        test_saturate();
        test_clear();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
